// File: rtl/dummy_zbt_pkg.sv
// Shared constants and types for the dummy ZBT SRAM model.
// ZBT_FLOWTHRU_EN selects flow-through (1-cycle) read latency.
package dummy_zbt_pkg;

  localparam int unsigned LOG_ADDR = 10;
  localparam int unsigned LOG_MEM  = 36;

`ifdef ZBT_FLOWTHRU_EN
  localparam int unsigned ZBT_READ_LATENCY = 1;
`else
  localparam int unsigned ZBT_READ_LATENCY = 2;
`endif

  typedef logic [LOG_ADDR-1:0] zbt_addr_t;
  typedef logic [LOG_MEM-1:0]  zbt_word_t;

endpackage

// File: rtl/zbt_mem_array.sv
// Plain synchronous word array: one write or one registered read per clock.
// Array contents are deliberately not reset; only the read register is.
module zbt_mem_array
  import dummy_zbt_pkg::*;
#(
  parameter int unsigned AW = dummy_zbt_pkg::LOG_ADDR,
  parameter int unsigned DW = dummy_zbt_pkg::LOG_MEM
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_wr,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd;

  always_ff @(posedge clock) begin
    if (i_wr) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read register only loads on read cycles so it holds across writes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd <= '0;
    end else if (!i_wr) begin
      r_rd <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rd;

endmodule

// File: rtl/dummy_zbt.sv
// Behavioural ZBT SRAM stand-in: input register stage, array, output stage.
// Define ZBT_FLOWTHRU_EN to bypass the output stage (1-cycle read latency).
module dummy_zbt
  import dummy_zbt_pkg::*;
#(
  parameter int unsigned LOG_ADDR = dummy_zbt_pkg::LOG_ADDR,
  parameter int unsigned LOG_MEM  = dummy_zbt_pkg::LOG_MEM
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr,
  input  logic [LOG_ADDR-1:0] addr,
  input  logic [LOG_MEM-1:0]  write,
  output logic [LOG_MEM-1:0]  data
);

  logic                r_wr1;
  logic [LOG_ADDR-1:0] r_addr1;
  logic [LOG_MEM-1:0]  r_write1;
  logic [LOG_MEM-1:0]  w_rd2;

  // Stage 1: capture the port op.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr1    <= 1'b0;
      r_addr1  <= '0;
      r_write1 <= '0;
    end else begin
      r_wr1    <= wr;
      r_addr1  <= addr;
      r_write1 <= write;
    end
  end

  zbt_mem_array #(
    .AW (LOG_ADDR),
    .DW (LOG_MEM)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .i_wr    (r_wr1),
    .i_addr  (r_addr1),
    .i_wdata (r_write1),
    .o_rdata (w_rd2)
  );

`ifdef ZBT_FLOWTHRU_EN
  assign data = w_rd2;
`else
  logic               r_rd_pend;
  logic [LOG_MEM-1:0] r_data;

  // Output stage retires only reads; writes leave the last result in place.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_pend <= 1'b0;
      r_data    <= '0;
    end else begin
      r_rd_pend <= !r_wr1;
      if (r_rd_pend) begin
        r_data <= w_rd2;
      end
    end
  end

  assign data = r_data;
`endif

endmodule

// File: tb/tb_dummy_zbt.sv
// Self-checking bench for dummy_zbt: directed table, bursts, resets, random ops.
module tb_dummy_zbt;
  import dummy_zbt_pkg::*;

  localparam int unsigned LAT   = ZBT_READ_LATENCY;
  localparam int unsigned DEPTH = 2 ** LOG_ADDR;

  logic      clock = 1'b0;
  logic      reset = 1'b0;
  logic      wr    = 1'b0;
  zbt_addr_t addr  = '0;
  zbt_word_t write = '0;
  zbt_word_t data;

  dummy_zbt u_dut (
    .clock (clock),
    .reset (reset),
    .wr    (wr),
    .addr  (addr),
    .write (write),
    .data  (data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic      wr;
    zbt_addr_t addr;
    zbt_word_t wdata;
    bit        chk;
    zbt_word_t exp;
  } vec_t;

  typedef struct {
    bit        rd;
    bit        known;
    zbt_word_t val;
    bit        has_exp;
    zbt_word_t exp;
  } ent_t;

  // Reference model: ops applied in program order, results retire LAT edges later.
  zbt_word_t m_mem   [DEPTH];
  bit        m_known [DEPTH];
  ent_t      pipe[$];
  zbt_word_t exp_data;
  bit        exp_known;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input zbt_word_t exp);
    checks++;
    if (data !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h exp %h", nm, $time, data, exp);
    end
  endtask

  task automatic op(input logic w, input zbt_addr_t a, input zbt_word_t d,
                    input bit he, input zbt_word_t e);
    ent_t en;
    ent_t p;
    bit   tchk;
    tchk = 1'b0;
    wr = w; addr = a; write = d;
    @(posedge clock);
    en.rd = !w; en.known = m_known[a]; en.val = m_mem[a];
    en.has_exp = he; en.exp = e;
    if (w) begin
      m_mem[a]   = d;
      m_known[a] = 1'b1;
    end
    pipe.push_back(en);
    if (pipe.size() > LAT) begin
      p = pipe.pop_front();
      if (p.rd) begin
        exp_known = p.known;
        exp_data  = p.val;
        tchk      = p.has_exp;
      end
    end
    #1;
    if (exp_known) chk("pipe", exp_data);
    if (tchk) chk("tbl", p.exp);
  endtask

  // After release the cleared stage 1 behaves like a read of address 0.
  task automatic model_reset_release();
    ent_t ph;
    pipe.delete();
    ph.rd = 1'b1; ph.known = m_known[0]; ph.val = m_mem[0];
    ph.has_exp = 1'b0; ph.exp = '0;
    pipe.push_back(ph);
    exp_data  = '0;
    exp_known = 1'b1;
  endtask

  vec_t      tbl [9];
  zbt_word_t ones;
  zbt_addr_t top_a;

  function automatic vec_t mk(input logic w, input zbt_addr_t a, input zbt_word_t d,
                              input bit c, input zbt_word_t e);
    vec_t v;
    v.wr = w; v.addr = a; v.wdata = d; v.chk = c; v.exp = e;
    return v;
  endfunction

  initial begin
    ones  = '1;
    top_a = zbt_addr_t'(DEPTH - 1);
    for (int i = 0; i < int'(DEPTH); i++) m_known[i] = 1'b0;
    tbl[0] = mk(1'b1, 10'd5,   36'd123, 1'b0, '0);
    tbl[1] = mk(1'b0, 10'd5,   '0,      1'b1, 36'd123);
    tbl[2] = mk(1'b1, 10'd7,   36'd11,  1'b0, '0);
    tbl[3] = mk(1'b0, 10'd7,   '0,      1'b1, 36'd11);
    tbl[4] = mk(1'b1, 10'd7,   36'd22,  1'b0, '0);
    tbl[5] = mk(1'b0, 10'd7,   '0,      1'b1, 36'd22);
    tbl[6] = mk(1'b1, top_a,   ones,    1'b0, '0);
    tbl[7] = mk(1'b0, top_a,   '0,      1'b1, ones);
    tbl[8] = mk(1'b0, 10'd0,   '0,      1'b1, 36'd1000);

    // Reset held over two edges.
    #1;
    chk("rst_t0", '0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      chk("rst_hold", '0);
    end
    reset = 1'b1;
    #1;
    chk("rst_release", '0);
    model_reset_release();

    // Write burst then read burst.
    for (int i = 0; i < 30; i++)
      op(1'b1, zbt_addr_t'(i), zbt_word_t'(1000 - i), 1'b0, '0);
    for (int i = 0; i < 30; i++)
      op(1'b0, zbt_addr_t'(i), '0, 1'b1, zbt_word_t'(1000 - i));

    // Directed corner cases.
    for (int i = 0; i < 9; i++)
      op(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].chk, tbl[i].exp);
    for (int i = 0; i < 3; i++) op(1'b0, 10'd1, '0, 1'b1, 36'd999);

    // Reset mid-read: in-flight read of addr 3 must never surface.
    op(1'b0, 10'd3, '0, 1'b0, '0);
    wr = 1'b0; addr = 10'd4;
    #1;
    reset = 1'b0;
    #1;
    chk("rst_async", '0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      chk("rst_mid_hold", '0);
    end
    reset = 1'b1;
    #1;
    chk("rst_mid_release", '0);
    model_reset_release();
    op(1'b0, 10'd3,  '0, 1'b1, 36'd997);
    op(1'b0, 10'd29, '0, 1'b1, 36'd971);
    op(1'b0, top_a,  '0, 1'b1, ones);
    op(1'b0, 10'd5,  '0, 1'b1, 36'd123);

    // Random mixed traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic      w;
      zbt_addr_t a;
      w = 1'($urandom_range(1));
      a = ($urandom_range(15) == 0) ? top_a : zbt_addr_t'($urandom_range(47));
      op(w, a, zbt_word_t'({$urandom, $urandom}), 1'b0, '0);
    end
    for (int i = 0; i < 4; i++) op(1'b0, 10'd0, '0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
